// File: rtl/approx_mult_sweep_checker.sv
// Sweeps all 256 operand pairs through an external 4x4 approximate multiplier
// and accumulates error statistics of its product against the exact product.
module approx_mult_sweep_checker #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [3:0]  A,
    output logic [3:0]  B,
    input  logic [7:0]  P,
    output logic        busy,
    output logic        done,
    output logic [15:0] sum_abs_err,
    output logic [8:0]  over_cnt,
    output logic [8:0]  under_cnt,
    output logic [7:0]  max_abs_err,
    output logic [3:0]  max_a,
    output logic [3:0]  max_b
);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t      state_reg;
    logic [7:0]  vec_cnt_reg;
    logic [3:0]  settle_cnt_reg;
    logic [7:0]  exact;
    logic [7:0]  diff;

    // Operands come straight from the vector counter register, so they are registered.
    assign A = vec_cnt_reg[7:4];
    assign B = vec_cnt_reg[3:0];

    assign exact = {4'b0, A} * {4'b0, B};
    assign diff  = (P > exact) ? (P - exact) : (exact - P);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            vec_cnt_reg    <= 8'd0;
            settle_cnt_reg <= 4'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            sum_abs_err    <= 16'd0;
            over_cnt       <= 9'd0;
            under_cnt      <= 9'd0;
            max_abs_err    <= 8'd0;
            max_a          <= 4'd0;
            max_b          <= 4'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg      <= DRIVE;
                        vec_cnt_reg    <= 8'd0;
                        settle_cnt_reg <= 4'd0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        sum_abs_err    <= 16'd0;
                        over_cnt       <= 9'd0;
                        under_cnt      <= 9'd0;
                        max_abs_err    <= 8'd0;
                        max_a          <= 4'd0;
                        max_b          <= 4'd0;
                    end
                end
                DRIVE: begin
                    if (settle_cnt_reg == SETTLE_LAST) begin
                        state_reg <= SAMPLE;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg + 4'd1;
                    end
                end
                SAMPLE: begin
                    sum_abs_err <= sum_abs_err + {8'd0, diff};
                    if (P > exact) begin
                        over_cnt <= over_cnt + 9'd1;
                    end else if (P < exact) begin
                        under_cnt <= under_cnt + 9'd1;
                    end
                    // Strict compare keeps the earliest vector on ties.
                    if (diff > max_abs_err) begin
                        max_abs_err <= diff;
                        max_a       <= A;
                        max_b       <= B;
                    end
                    if (vec_cnt_reg == 8'd255) begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        vec_cnt_reg    <= vec_cnt_reg + 8'd1;
                        settle_cnt_reg <= 4'd0;
                        state_reg      <= DRIVE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_approx_mult_sweep_checker.sv
// Drives two checkers (SETTLE=1 and SETTLE=3) from one product table and compares
// their statistics and sweep timing with a vector-by-vector reference computation.
module tb_approx_mult_sweep_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;

    logic [3:0]  a1, b1, ma1, mb1, a3, b3, ma3, mb3;
    logic [7:0]  p1, p3, mx1, mx3;
    logic        busy1, done1, busy3, done3;
    logic [15:0] sum1, sum3;
    logic [8:0]  ov1, un1, ov3, un3;

    logic [7:0] p_tbl [256];

    int checks = 0;
    int errors = 0;
    int e_sum, e_over, e_under, e_max, e_ma, e_mb;

    always #5 clk = ~clk;

    // Multiplier under test: a lookup table indexed by the operand pair.
    assign p1 = p_tbl[{a1, b1}];
    assign p3 = p_tbl[{a3, b3}];

    approx_mult_sweep_checker #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .A(a1), .B(b1), .P(p1),
        .busy(busy1), .done(done1), .sum_abs_err(sum1), .over_cnt(ov1),
        .under_cnt(un1), .max_abs_err(mx1), .max_a(ma1), .max_b(mb1));

    approx_mult_sweep_checker #(.SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .A(a3), .B(b3), .P(p3),
        .busy(busy3), .done(done3), .sum_abs_err(sum3), .over_cnt(ov3),
        .under_cnt(un3), .max_abs_err(mx3), .max_a(ma3), .max_b(mb3));

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mode 0 exact, 1 zero, 2 all-ones, 3 single +4 error at (7,9), 4 random, 5 exact+-noise
    task automatic fill(input int mode);
        for (int v = 0; v < 256; v++) begin
            int ex;
            int n;
            ex = (v / 16) * (v % 16);
            case (mode)
                0: p_tbl[v] = 8'(ex);
                1: p_tbl[v] = 8'd0;
                2: p_tbl[v] = 8'hFF;
                3: p_tbl[v] = (v == 7 * 16 + 9) ? 8'(ex + 4) : 8'(ex);
                4: p_tbl[v] = 8'($urandom_range(0, 255));
                default: begin
                    n = ex + $urandom_range(0, 6) - 3;
                    if (n < 0) n = 0;
                    p_tbl[v] = 8'(n);
                end
            endcase
        end
    endtask

    task automatic model();
        e_sum = 0; e_over = 0; e_under = 0; e_max = 0; e_ma = 0; e_mb = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                int p;
                int d;
                p = int'(p_tbl[a * 16 + b]);
                d = (p > a * b) ? p - a * b : a * b - p;
                e_sum += d;
                if (p > a * b) e_over++;
                if (p < a * b) e_under++;
                if (d > e_max) begin
                    e_max = d; e_ma = a; e_mb = b;
                end
            end
        end
    endtask

    task automatic check_stats(input string who, input int s, input int o, input int u,
                               input int m, input int ma, input int mb);
        chk({who, ".sum"}, s, e_sum);
        chk({who, ".over"}, o, e_over);
        chk({who, ".under"}, u, e_under);
        chk({who, ".max"}, m, e_max);
        chk({who, ".max_a"}, ma, e_ma);
        chk({who, ".max_b"}, mb, e_mb);
    endtask

    task automatic run_sweep(input string name, input bit hold);
        int t1;
        int t3;
        int t1b;
        model();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        chk({name, ".busy_at_start"}, busy1, 1);
        chk({name, ".done_cleared"}, {done1, done3}, 0);
        chk({name, ".ab_at_start"}, {a1, b1, a3, b3}, 0);
        chk({name, ".sum_cleared"}, sum1, 0);
        if (!hold) start = 1'b0;
        t1 = 0;
        t3 = 0;
        for (int cyc = 1; cyc <= 1100 && (t1 == 0 || t3 == 0); cyc++) begin
            @(posedge clk);
            #1;
            if (done1 && t1 == 0) t1 = cyc;
            if (done3 && t3 == 0) t3 = cyc;
            if (hold && cyc == 513) begin
                chk({name, ".restart_busy"}, busy1, 1);
                chk({name, ".restart_done"}, done1, 0);
            end
        end
        start = 1'b0;
        chk({name, ".latency1"}, t1, 512);
        chk({name, ".latency3"}, t3, 1024);
        chk({name, ".busy3_end"}, busy3, 0);
        check_stats({name, ".s3"}, sum3, ov3, un3, mx3, ma3, mb3);
        if (hold) begin
            t1b = 0;
            for (int cyc = 0; cyc < 600 && t1b == 0; cyc++) begin
                @(posedge clk);
                #1;
                if (done1) t1b = 1;
            end
            chk({name, ".second_sweep_done"}, t1b, 1);
        end
        check_stats({name, ".s1"}, sum1, ov1, un1, mx1, ma1, mb1);
        $display("sweep %s: lat1=%0d lat3=%0d sum=%0d over=%0d under=%0d max=%0d at (%0d,%0d)",
                 name, t1, t3, sum3, ov3, un3, mx3, ma3, mb3);
    endtask

    initial begin
        fill(0);
        #1;
        chk("reset_state1", {a1, b1, busy1, done1, sum1, ov1, un1, mx1, ma1, mb1}, 0);
        chk("reset_state3", {a3, b3, busy3, done3, sum3, ov3, un3, mx3, ma3, mb3}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        fill(0); run_sweep("exact", 1'b0);
        fill(1); run_sweep("zero", 1'b0);
        fill(2); run_sweep("ones", 1'b0);
        fill(3); run_sweep("single", 1'b0);
        fill(4); run_sweep("random", 1'b0);
        fill(5); run_sweep("noisy", 1'b0);

        // Abort mid-sweep with an asynchronous reset pulse.
        fill(4);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (100) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_reset1", {a1, b1, busy1, done1, sum1, ov1, un1, mx1, ma1, mb1}, 0);
        chk("async_reset3", {a3, b3, busy3, done3, sum3, ov3, un3, mx3, ma3, mb3}, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_reset", {busy1, done1, busy3, done3}, 0);
        run_sweep("post_reset", 1'b0);

        fill(5); run_sweep("held_start", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
